// File: rtl/rc_frame_parser.sv
// RC command frame parser: SYNC, 4 channel bytes, 8-bit additive checksum, with inter-byte timeout.
// Optional link-loss failsafe is built when PARSER_FAILSAFE_EN is defined.
module rc_frame_parser #(
   parameter logic [7:0]  SYNC_BYTE       = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES  = 27000,
   parameter int unsigned FAILSAFE_CYCLES = 2700000
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       avail,
   input  logic [7:0] data,
   output logic [7:0] ch_throttle,
   output logic [7:0] ch_roll,
   output logic [7:0] ch_pitch,
   output logic [7:0] ch_yaw,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [7:0] err_cnt,
   output logic       failsafe
);

   typedef enum logic [2:0] {HUNT, CH0, CH1, CH2, CH3, CSUM} state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t          state, state_nx;
   logic            avail_d;
   logic            strb;
   logic [15:0]     gap;
   logic [7:0]      sum;
   logic [3:0][7:0] sh;
   logic            timeout, commit, bad_csum;
   logic            fs_hit;

   assign strb = avail & ~avail_d;

   // A byte arriving on the same edge the gap expires is still consumed.
   assign timeout = (state != HUNT) && !strb && (gap == TMO_LAST);

   always_comb begin
      state_nx = state;
      commit   = 1'b0;
      bad_csum = 1'b0;
      case (state)
         HUNT: if (strb && data == SYNC_BYTE) state_nx = CH0;
         CH0:  if (strb) state_nx = CH1;
         CH1:  if (strb) state_nx = CH2;
         CH2:  if (strb) state_nx = CH3;
         CH3:  if (strb) state_nx = CSUM;
         CSUM: if (strb) begin
            state_nx = HUNT;
            if (data == sum) commit   = 1'b1;
            else             bad_csum = 1'b1;
         end
         default: state_nx = HUNT;
      endcase
      if (timeout) state_nx = HUNT;
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state       <= HUNT;
         avail_d     <= 1'b1;
         gap         <= '0;
         sum         <= '0;
         sh          <= '0;
         frame_ok    <= 1'b0;
         frame_err   <= 1'b0;
         err_cnt     <= '0;
         ch_throttle <= '0;
         ch_roll     <= '0;
         ch_pitch    <= '0;
         ch_yaw      <= '0;
      end else begin
         state   <= state_nx;
         avail_d <= avail;

         if (strb || state_nx == HUNT) gap <= '0;
         else                          gap <= gap + 16'd1;

         if (strb) begin
            case (state)
               HUNT: if (data == SYNC_BYTE) sum <= '0;
               CH0:  begin sh[0] <= data; sum <= sum + data; end
               CH1:  begin sh[1] <= data; sum <= sum + data; end
               CH2:  begin sh[2] <= data; sum <= sum + data; end
               CH3:  begin sh[3] <= data; sum <= sum + data; end
               default: ;
            endcase
         end

         frame_ok  <= commit;
         frame_err <= bad_csum | timeout;
         if ((bad_csum | timeout) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

         if (commit) begin
            ch_throttle <= sh[0];
            ch_roll     <= sh[1];
            ch_pitch    <= sh[2];
            ch_yaw      <= sh[3];
         end else if (fs_hit) begin
            ch_throttle <= '0;
         end
      end
   end

`ifdef PARSER_FAILSAFE_EN
   localparam logic [21:0] FS_MAX = 22'(FAILSAFE_CYCLES);

   logic [21:0] fs_cnt, fs_nx;

   always_comb begin
      fs_nx = fs_cnt;
      if (commit)                fs_nx = '0;
      else if (fs_cnt != FS_MAX) fs_nx = fs_cnt + 22'd1;
   end

   assign fs_hit = !commit && (fs_nx == FS_MAX);

   // A good frame both reloads the channels and clears the flag on one edge.
   always_ff @(posedge clock) begin
      if (rst) begin
         fs_cnt   <= '0;
         failsafe <= 1'b1;
      end else begin
         fs_cnt <= fs_nx;
         if (commit)      failsafe <= 1'b0;
         else if (fs_hit) failsafe <= 1'b1;
      end
   end
`else
   assign fs_hit   = 1'b0;
   assign failsafe = 1'b0;
`endif

endmodule

// File: tb/tb_rc_frame_parser.sv
// Directed bench for rc_frame_parser: good/bad frames, timeout edge, stale avail, sync in payload,
// err_cnt saturation, and failsafe (or its absence) depending on PARSER_FAILSAFE_EN.
module tb_rc_frame_parser;

   localparam int TMO = 50;
   localparam int FS  = 1000;

   logic       clock = 1'b0;
   logic       rst   = 1'b1;
   logic       avail = 1'b0;
   logic [7:0] data  = 8'h00;
   logic [7:0] ch_throttle, ch_roll, ch_pitch, ch_yaw, err_cnt;
   logic       frame_ok, frame_err, failsafe;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ok_n  = 0;
   int err_n = 0;
   int err_cyc = -1;
   int last_strb = 0;
   int ok0, err0, wait_n;

   rc_frame_parser #(
      .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO), .FAILSAFE_CYCLES(FS)
   ) dut (
      .clock(clock), .rst(rst), .avail(avail), .data(data),
      .ch_throttle(ch_throttle), .ch_roll(ch_roll), .ch_pitch(ch_pitch), .ch_yaw(ch_yaw),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt), .failsafe(failsafe)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Pulse monitor: one count per cycle the pulse is high, so a stretched pulse over-counts.
   always @(negedge clock) begin
      if (frame_ok) ok_n <= ok_n + 1;
      if (frame_err) begin
         err_n   <= err_n + 1;
         err_cyc <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_ch(input string tag, input logic [7:0] t, r, p, y);
      chk({tag, ".thr"}, ch_throttle, t);
      chk({tag, ".rol"}, ch_roll, r);
      chk({tag, ".pit"}, ch_pitch, p);
      chk({tag, ".yaw"}, ch_yaw, y);
   endtask

   // Called at #1 after a posedge with avail low; strobe lands on the first edge.
   task automatic send_byte(input logic [7:0] b);
      data  = b;
      avail = 1'b1;
      @(posedge clock); #1;
      last_strb = cyc;
      @(posedge clock); #1;
      avail = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic send6(input logic [7:0] a, b, c, d, e, f);
      send_byte(a); send_byte(b); send_byte(c);
      send_byte(d); send_byte(e); send_byte(f);
   endtask

   task automatic do_reset(input logic hold_avail);
      avail = hold_avail;
      data  = 8'hA5;
      rst   = 1'b1;
      repeat (3) @(posedge clock);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic fs_rst;
`ifdef PARSER_FAILSAFE_EN
      fs_rst = 1'b1;
`else
      fs_rst = 1'b0;
`endif
      do_reset(1'b0);
      repeat (2) @(posedge clock); #1;
      chk_ch("rst", 8'h00, 8'h00, 8'h00, 8'h00);
      chk("rst.errcnt", err_cnt, 8'd0);
      chk("rst.ok", frame_ok, 1'b0);
      chk("rst.err", frame_err, 1'b0);
      chk("rst.fs", failsafe, fs_rst);

      // Good frame
      ok0 = ok_n; err0 = err_n;
      send6(8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0);
      chk_ch("good", 8'h10, 8'h20, 8'h30, 8'h40);
      chk("good.okpulses", ok_n - ok0, 1);
      chk("good.errcnt", err_cnt, 8'd0);
      chk("good.fs", failsafe, 1'b0);

      // Bad checksum, then recovery
      ok0 = ok_n; err0 = err_n;
      send6(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B);
      chk("badcs.errpulses", err_n - err0, 1);
      chk("badcs.okpulses", ok_n - ok0, 0);
      chk("badcs.errcnt", err_cnt, 8'd1);
      chk_ch("badcs.hold", 8'h10, 8'h20, 8'h30, 8'h40);
      send6(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
      chk_ch("badcs.next", 8'h01, 8'h02, 8'h03, 8'h04);

      // Timeout exactly TMO edges after the last strobe
      err0 = err_n;
      send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
      repeat (TMO + 10) @(posedge clock); #1;
      chk("tmo.errpulses", err_n - err0, 1);
      chk("tmo.cycle", err_cyc, last_strb + TMO);
      chk("tmo.errcnt", err_cnt, 8'd2);
      ok0 = ok_n;
      send6(8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
      chk_ch("tmo.next", 8'h11, 8'h22, 8'h33, 8'h44);
      chk("tmo.next.ok", ok_n - ok0, 1);

      // Leading garbage, sync value in payload
      ok0 = ok_n; err0 = err_n;
      send_byte(8'h00); send_byte(8'hFF);
      send6(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h94);
      chk_ch("sync", 8'hA5, 8'hA5, 8'hA5, 8'hA5);
      chk("sync.ok", ok_n - ok0, 1);
      chk("sync.err", err_n - err0, 0);

      // Mid-frame reset with avail held high at sync across release
      send_byte(8'hA5); send_byte(8'h11);
      do_reset(1'b1);
      repeat (3) @(posedge clock); #1;
      chk_ch("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
      chk("midrst.errcnt", err_cnt, 8'd0);
      avail = 1'b0;
      @(posedge clock); #1;
      ok0 = ok_n;
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      send_byte(8'h04); send_byte(8'h0A);
      chk("stale.ok", ok_n - ok0, 0);
      chk("stale.thr", ch_throttle, 8'h00);
      send6(8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0);
      chk_ch("stale.next", 8'h10, 8'h20, 8'h30, 8'h40);

      // Byte arriving on the very edge the gap would expire
      ok0 = ok_n; err0 = err_n;
      send_byte(8'hA5);
      wait_n = last_strb + TMO - 1 - cyc;
      repeat (wait_n) @(posedge clock);
      #1;
      send_byte(8'h05);
      chk("race.edge", last_strb - (cyc - 2), 0);
      send_byte(8'h06); send_byte(8'h07); send_byte(8'h08); send_byte(8'h1A);
      chk("race.err", err_n - err0, 0);
      chk("race.ok", ok_n - ok0, 1);
      chk_ch("race", 8'h05, 8'h06, 8'h07, 8'h08);

      // err_cnt saturation
      err0 = err_n;
      for (int i = 0; i < 256; i++) send6(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B);
      chk("sat.pulses", err_n - err0, 256);
      chk("sat.errcnt", err_cnt, 8'hFF);

      // Link loss
      send6(8'hA5, 8'h80, 8'h20, 8'h30, 8'h40, 8'h10);
      chk("fs.pre", failsafe, 1'b0);
      chk("fs.pre.thr", ch_throttle, 8'h80);
      repeat (FS + 10) @(posedge clock); #1;
`ifdef PARSER_FAILSAFE_EN
      chk("fs.flag", failsafe, 1'b1);
      chk("fs.thr", ch_throttle, 8'h00);
`else
      chk("fs.flag", failsafe, 1'b0);
      chk("fs.thr", ch_throttle, 8'h80);
`endif
      chk("fs.rol", ch_roll, 8'h20);
      send6(8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14);
      chk("fs.clear", failsafe, 1'b0);
      chk_ch("fs.next", 8'h12, 8'h34, 8'h56, 8'h78);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
